cs_codeword_serializer: RTL and testbench

- Downstream stage of the static cyclic-shift encoder.
- Accepts one complete K-symbol codeword in parallel, (L-1) bits per symbol, through a valid/ready handshake.
- Emits the symbols one per cycle, row 0 first, on a symbol stream with index and last flags.
- Decouples the wide combinational encoder output from the narrow link/packet interface.

---
 rtl/cs_pkg.sv | 14 +
 rtl/cs_codeword_serializer_next_row.sv | 25 ++
 rtl/cs_codeword_serializer.sv | 117 +++++++++++
 tb/tb_cs_codeword_serializer.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cs_pkg.sv
// Shared widths, symbol/codeword types and FSM states for the codeword serializer.
package cs_pkg;

    localparam int unsigned K     = 5;
    localparam int unsigned L     = 11;
    localparam int unsigned SYM_W = L - 1;
    localparam int unsigned IDX_W = (K > 1) ? $clog2(K) : 1;

    typedef logic [SYM_W-1:0] sym_t;
    typedef sym_t [K-1:0]     cw_t;

    typedef enum logic {IDLE, SEND} state_e;

endpackage

// File: rtl/cs_codeword_serializer_next_row.sv
// Lowest-set-bit-at-or-above finder over the row mask; only built with CS_SER_ROW_MASK_EN.
`ifdef CS_SER_ROW_MASK_EN
module cs_next_row
    import cs_pkg::*;
(
    input  logic [K-1:0]     mask_i,
    input  logic [IDX_W:0]   from_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             found_o
);

    // Scan downwards so the lowest qualifying row is the one that sticks.
    always_comb begin
        idx_o   = '0;
        found_o = 1'b0;
        for (int i = int'(K) - 1; i >= 0; i--) begin
            if (mask_i[i] && (int'(from_i) <= i)) begin
                idx_o   = IDX_W'(i);
                found_o = 1'b1;
            end
        end
    end

endmodule
`endif

// File: rtl/cs_codeword_serializer.sv
// Buffers one K-symbol codeword and streams it out one symbol per handshake, row 0 first.
// Optional CS_SER_ROW_MASK_EN adds row_mask_i to emit only the selected rows.
module cs_codeword_serializer
    import cs_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             cw_valid_i,
    output logic             cw_ready_o,
    input  cw_t              cw_data_i,
`ifdef CS_SER_ROW_MASK_EN
    input  logic [K-1:0]     row_mask_i,
`endif
    output logic             sym_valid_o,
    input  logic             sym_ready_i,
    output sym_t             sym_data_o,
    output logic [IDX_W-1:0] sym_idx_o,
    output logic             sym_last_o
);

    state_e           state_q, state_d;
    cw_t              buf_q, buf_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             is_last;
    logic             cw_acc;
    logic             sym_hs;

`ifdef CS_SER_ROW_MASK_EN
    logic [K-1:0]     mask_q, mask_d;
    logic [IDX_W-1:0] start_idx, next_idx;
    logic             start_found, next_found;
    logic [IDX_W:0]   next_from;

    assign next_from = (IDX_W+1)'(idx_q) + (IDX_W+1)'(1);

    cs_next_row u_start_row (
        .mask_i  (row_mask_i),
        .from_i  ('0),
        .idx_o   (start_idx),
        .found_o (start_found)
    );

    cs_next_row u_next_row (
        .mask_i  (mask_q),
        .from_i  (next_from),
        .idx_o   (next_idx),
        .found_o (next_found)
    );

    // Last symbol is the one with no selected row above it.
    assign is_last = !next_found;
`else
    assign is_last = (idx_q == IDX_W'(K - 1));
`endif

    always_comb begin
        sym_valid_o = (state_q == SEND);
        sym_data_o  = sym_valid_o ? buf_q[idx_q] : '0;
        sym_idx_o   = idx_q;
        sym_last_o  = sym_valid_o && is_last;
        // Refill is allowed in the same cycle the last symbol leaves.
        cw_ready_o  = (state_q == IDLE) || (sym_ready_i && is_last);
    end

    assign cw_acc = cw_valid_i && cw_ready_o;
    assign sym_hs = sym_valid_o && sym_ready_i;

    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        idx_d   = idx_q;
`ifdef CS_SER_ROW_MASK_EN
        mask_d  = mask_q;
`endif
        if (cw_acc) begin
            buf_d = cw_data_i;
`ifdef CS_SER_ROW_MASK_EN
            mask_d  = row_mask_i;
            idx_d   = start_found ? start_idx : '0;
            state_d = start_found ? SEND : IDLE;
`else
            idx_d   = '0;
            state_d = SEND;
`endif
        end else if (sym_hs) begin
            if (is_last) begin
                state_d = IDLE;
                idx_d   = '0;
            end else begin
`ifdef CS_SER_ROW_MASK_EN
                idx_d = next_idx;
`else
                idx_d = idx_q + IDX_W'(1);
`endif
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            buf_q   <= '0;
            idx_q   <= '0;
`ifdef CS_SER_ROW_MASK_EN
            mask_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            idx_q   <= idx_d;
`ifdef CS_SER_ROW_MASK_EN
            mask_q  <= mask_d;
`endif
        end
    end

endmodule

// File: tb/tb_cs_codeword_serializer.sv
// Self-checking bench for cs_codeword_serializer: symbol scoreboard, vector table, corner sequences.
module tb_cs_codeword_serializer;
    import cs_pkg::*;

    logic             clk = 1'b0;
    logic             rst_i;
    logic             cw_valid_i;
    logic             cw_ready_o;
    cw_t              cw_data_i;
`ifdef CS_SER_ROW_MASK_EN
    logic [K-1:0]     row_mask_i;
`endif
    logic             sym_valid_o;
    logic             sym_ready_i;
    sym_t             sym_data_o;
    logic [IDX_W-1:0] sym_idx_o;
    logic             sym_last_o;

    always #5 clk = ~clk;

    cs_codeword_serializer dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .cw_valid_i  (cw_valid_i),
        .cw_ready_o  (cw_ready_o),
        .cw_data_i   (cw_data_i),
`ifdef CS_SER_ROW_MASK_EN
        .row_mask_i  (row_mask_i),
`endif
        .sym_valid_o (sym_valid_o),
        .sym_ready_i (sym_ready_i),
        .sym_data_o  (sym_data_o),
        .sym_idx_o   (sym_idx_o),
        .sym_last_o  (sym_last_o)
    );

    typedef struct packed {
        sym_t             data;
        logic [IDX_W-1:0] idx;
        logic             last;
    } exp_t;

    typedef struct {
        cw_t        cw;
        logic [7:0] ready_pat;
        sym_t       exp_first;
        sym_t       exp_last;
    } vec_t;

    exp_t         sb_q[$];
    exp_t         sb_e;
    int           n_tests = 0;
    int           n_fail  = 0;
    int           n_hs    = 0;
    logic [K-1:0] mon_mask;
    int           mon_hi;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: pop on every symbol handshake, push the model's symbols on every accept.
    always @(negedge clk) begin
        if (rst_i) begin
            sb_q.delete();
        end else begin
            if (sym_valid_o && sym_ready_i) begin
                n_hs++;
                if (sb_q.size() == 0) begin
                    chk("sb_unexpected_symbol", sb_q.size(), 1);
                end else begin
                    sb_e = sb_q.pop_front();
                    chk("sb_data", sym_data_o, sb_e.data);
                    chk("sb_idx", sym_idx_o, sb_e.idx);
                    chk("sb_last", sym_last_o, sb_e.last);
                end
            end
            if (cw_valid_i && cw_ready_o) begin
`ifdef CS_SER_ROW_MASK_EN
                mon_mask = row_mask_i;
`else
                mon_mask = '1;
`endif
                mon_hi = -1;
                for (int r = 0; r < int'(K); r++) if (mon_mask[r]) mon_hi = r;
                for (int r = 0; r < int'(K); r++) begin
                    if (mon_mask[r]) sb_q.push_back({cw_data_i[r], IDX_W'(r), (r == mon_hi)});
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    cw_t  cw_t1, cw_t2, cw_r;
    vec_t vecs[4];
    int   h0, acc, gap, acc2_c, got;
    logic hs_now, done, prev_stall;
    sym_t first_d, last_d, prev_data;
    logic [IDX_W-1:0] prev_idx;
    logic prev_last;

    initial begin
        cw_t1 = {10'h155, 10'h3FF, 10'h004, 10'h002, 10'h001};
        cw_t2 = {10'h0AB, 10'h2CD, 10'h1EF, 10'h301, 10'h077};
        cw_r  = {10'h3A5, 10'h25A, 10'h0C3, 10'h13C, 10'h099};
        vecs[0] = '{cw: cw_t1, ready_pat: 8'hFF, exp_first: 10'h001, exp_last: 10'h155};
        vecs[1] = '{cw: {10'h3C3, 10'h00F, 10'h0F0, 10'h155, 10'h2AA}, ready_pat: 8'b1111_1001,
                    exp_first: 10'h2AA, exp_last: 10'h3C3};
        vecs[2] = '{cw: {10'h123, 10'h000, 10'h3FF, 10'h000, 10'h3FF}, ready_pat: 8'b1010_1010,
                    exp_first: 10'h3FF, exp_last: 10'h123};
        vecs[3] = '{cw: {10'h3FE, 10'h020, 10'h040, 10'h080, 10'h100}, ready_pat: 8'b0000_0110,
                    exp_first: 10'h100, exp_last: 10'h3FE};

        rst_i       = 1'b1;
        cw_valid_i  = 1'b0;
        cw_data_i   = '0;
        sym_ready_i = 1'b1;
`ifdef CS_SER_ROW_MASK_EN
        row_mask_i  = '1;
`endif
        step;
        step;
        rst_i = 1'b0;
        chk("rst_sym_valid", sym_valid_o, 0);
        chk("rst_sym_data", sym_data_o, 0);
        chk("rst_sym_idx", sym_idx_o, 0);
        chk("rst_sym_last", sym_last_o, 0);
        chk("rst_cw_ready", cw_ready_o, 1);

        // Single codeword, cycle-exact.
        cw_data_i  = cw_t1;
        cw_valid_i = 1'b1;
        step;
        cw_valid_i = 1'b0;
        cw_data_i  = '1;
        for (int c = 1; c <= 5; c++) begin
            chk("t1_valid", sym_valid_o, 1);
            chk("t1_idx", sym_idx_o, c - 1);
            chk("t1_data", sym_data_o, cw_t1[c-1]);
            chk("t1_last", sym_last_o, (c == 5));
            if (c < 5) chk("t1_cw_ready_low", cw_ready_o, 0);
            step;
        end
        chk("t1_back_idle", sym_valid_o, 0);

        // Back-to-back codewords with no bubble.
        h0 = n_hs; acc = 0; gap = 0; acc2_c = -1;
        cw_data_i  = cw_t1;
        cw_valid_i = 1'b1;
        for (int c = 0; c < 12; c++) begin
            if (c >= 1 && c <= 10 && !sym_valid_o) gap++;
            hs_now = cw_valid_i && cw_ready_o;
            step;
            if (hs_now) begin
                acc++;
                if (acc == 1) cw_data_i = cw_t2;
                else begin
                    cw_valid_i = 1'b0;
                    acc2_c     = c;
                end
            end
        end
        chk("b2b_accepts", acc, 2);
        chk("b2b_accept_on_last", acc2_c, 5);
        chk("b2b_no_gap", gap, 0);
        chk("b2b_handshakes", n_hs - h0, 10);

        // Vector table with stall patterns.
        for (int v = 0; v < 4; v++) begin
            h0 = n_hs; got = 0; done = 1'b0; prev_stall = 1'b0;
            first_d = '0; last_d = '0;
            chk("vec_idle_ready", cw_ready_o, 1);
            cw_data_i  = vecs[v].cw;
            cw_valid_i = 1'b1;
            step;
            cw_valid_i = 1'b0;
            cw_data_i  = '1;
            for (int c = 0; c < 40 && !done; c++) begin
                sym_ready_i = (c < 8) ? vecs[v].ready_pat[c] : 1'b1;
                if (c == 0) chk("vec_latency", sym_valid_o, 1);
                if (prev_stall) begin
                    chk("stall_data", sym_data_o, prev_data);
                    chk("stall_idx", sym_idx_o, prev_idx);
                    chk("stall_last", sym_last_o, prev_last);
                    chk("stall_valid", sym_valid_o, 1);
                end
                if (sym_valid_o && sym_ready_i) begin
                    if (got == 0) first_d = sym_data_o;
                    got++;
                    if (sym_last_o) begin
                        last_d = sym_data_o;
                        done   = 1'b1;
                    end
                end
                prev_stall = sym_valid_o && !sym_ready_i;
                prev_data  = sym_data_o;
                prev_idx   = sym_idx_o;
                prev_last  = sym_last_o;
                step;
            end
            sym_ready_i = 1'b1;
            chk("vec_done", done, 1);
            chk("vec_first", first_d, vecs[v].exp_first);
            chk("vec_last", last_d, vecs[v].exp_last);
            chk("vec_count", got, K);
            chk("vec_hs_count", n_hs - h0, K);
        end

        // Reset while idx == 2.
        cw_data_i  = cw_r;
        cw_valid_i = 1'b1;
        step;
        cw_valid_i = 1'b0;
        step;
        step;
        chk("rst_mid_idx2", sym_idx_o, 2);
        rst_i = 1'b1;
        step;
        rst_i = 1'b0;
        chk("rst_mid_valid", sym_valid_o, 0);
        chk("rst_mid_idx", sym_idx_o, 0);
        chk("rst_mid_last", sym_last_o, 0);
        chk("rst_mid_cw_ready", cw_ready_o, 1);
        cw_data_i  = cw_t2;
        cw_valid_i = 1'b1;
        step;
        cw_valid_i = 1'b0;
        chk("rst_after_idx0", sym_idx_o, 0);
        chk("rst_after_data", sym_data_o, cw_t2[0]);
        repeat (K) step;
        chk("rst_after_idle", sym_valid_o, 0);

`ifdef CS_SER_ROW_MASK_EN
        // Sparse mask: rows 3 and 4 only.
        h0 = n_hs;
        row_mask_i = 5'b11000;
        cw_data_i  = cw_t1;
        cw_valid_i = 1'b1;
        step;
        cw_valid_i = 1'b0;
        row_mask_i = '1;
        chk("mask_first_idx", sym_idx_o, 3);
        chk("mask_first_data", sym_data_o, cw_t1[3]);
        chk("mask_first_last", sym_last_o, 0);
        step;
        chk("mask_second_idx", sym_idx_o, 4);
        chk("mask_second_last", sym_last_o, 1);
        step;
        chk("mask_done_idle", sym_valid_o, 0);
        chk("mask_hs_count", n_hs - h0, 2);

        // Empty mask: accepted and dropped.
        row_mask_i = '0;
        cw_data_i  = cw_r;
        cw_valid_i = 1'b1;
        step;
        chk("mask_zero_valid", sym_valid_o, 0);
        chk("mask_zero_ready", cw_ready_o, 1);
        row_mask_i = '1;
        cw_data_i  = cw_t2;
        step;
        cw_valid_i = 1'b0;
        chk("mask_zero_next_valid", sym_valid_o, 1);
        chk("mask_zero_next_idx", sym_idx_o, 0);
        repeat (K) step;
`endif

        chk("sb_drained", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
